// File: rtl/blinds_motor_ctrl.sv
// Blinds motor controller: moves the blind position toward a latched preset,
// with a motor-off dead time before every direction change.
module blinds_motor_ctrl #(
    parameter int POS_W    = 8,
    parameter int SEL_W    = 2,
    parameter int MAX_POS  = (1 << POS_W) - 1,
    parameter int DEAD_CYC = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [(2**SEL_W)*POS_W-1:0]     presets,
    input  logic [SEL_W-1:0]                sel,
    input  logic                            go,
    input  logic                            stop,
    input  logic                            step_en,
    output logic [POS_W-1:0]                pos,
    output logic                            motor_up,
    output logic                            motor_down,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        BRAKE = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] MAXP  = POS_W'(MAX_POS);
    localparam logic [3:0]       DC_LD = 4'(DEAD_CYC - 1);

    state_t           st_q, st_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic             pend_q, pend_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_d;
    logic             up_q, dn_q, busy_q, done_q;
    logic [POS_W-1:0] raw_tgt;
    logic [POS_W-1:0] go_tgt;
    logic             req;

    // Requested target, clamped to the fully-open limit.
    always_comb begin
        raw_tgt = presets[int'(sel)*POS_W +: POS_W];
        go_tgt  = (raw_tgt > MAXP) ? MAXP : raw_tgt;
    end

    // Next-state: stepping first, then stop/go/arrival decisions
    // against the post-step position.
    always_comb begin
        st_d   = st_q;
        pos_d  = pos_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        req    = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (go && !stop) begin
                    tgt_d = go_tgt;
                    if (go_tgt > pos_q)      st_d = UP;
                    else if (go_tgt < pos_q) st_d = DOWN;
                    else                     done_d = 1'b1;
                end
            end
            UP, DOWN: begin
                if (step_en) begin
                    if (st_q == UP && pos_q < MAXP)
                        pos_d = pos_q + 1'b1;
                    if (st_q == DOWN && pos_q != '0)
                        pos_d = pos_q - 1'b1;
                end
                if (stop) begin
                    st_d   = BRAKE;
                    pend_d = 1'b0;
                    cnt_d  = DC_LD;
                end else if (go) begin
                    tgt_d = go_tgt;
                    if (go_tgt == pos_d) begin
                        st_d   = IDLE;
                        done_d = 1'b1;
                    end else if ((st_q == UP) != (go_tgt > pos_d)) begin
                        st_d   = BRAKE;
                        pend_d = 1'b1;
                        cnt_d  = DC_LD;
                    end
                end else if (pos_d == tgt_q) begin
                    st_d   = IDLE;
                    done_d = 1'b1;
                end
            end
            BRAKE: begin
                if (stop) begin
                    pend_d = 1'b0;
                end else if (go) begin
                    tgt_d  = go_tgt;
                    pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    req    = pend_d;
                    pend_d = 1'b0;
                    st_d   = IDLE;
                    if (req) begin
                        if (tgt_d > pos_q)      st_d = UP;
                        else if (tgt_d < pos_q) st_d = DOWN;
                        else                    done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // State and registered outputs; reset overrides every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            pos_q  <= '0;
            tgt_q  <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            up_q   <= 1'b0;
            dn_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            pos_q  <= pos_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            up_q   <= (st_d == UP);
            dn_q   <= (st_d == DOWN);
            busy_q <= (st_d != IDLE);
            done_q <= done_d;
        end
    end

    assign pos        = pos_q;
    assign motor_up   = up_q;
    assign motor_down = dn_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_blinds_motor_ctrl.sv
// Bench for blinds_motor_ctrl: directed scenarios plus random traffic,
// all cycles checked against a direction/brake-countdown reference model.
module tb_blinds_motor_ctrl;

    localparam int POS_W = 8;
    localparam int SEL_W = 2;
    localparam int MAXP  = 200;
    localparam int DEAD  = 2;
    localparam int NP    = 2**SEL_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NP*POS_W-1:0]   presets = '0;
    logic [SEL_W-1:0]      sel = '0;
    logic                  go = 1'b0;
    logic                  stop = 1'b0;
    logic                  step_en = 1'b0;
    logic [POS_W-1:0]      pos;
    logic                  motor_up;
    logic                  motor_down;
    logic                  busy;
    logic                  done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: signed direction, remaining brake cycles,
    // a pending-request flag, and integer position/target.
    int m_pos = 0, m_tgt = 0, m_dir = 0, m_brake = 0, m_pend = 0, m_done = 0;

    always #5 clk = ~clk;

    blinds_motor_ctrl #(
        .POS_W(POS_W), .SEL_W(SEL_W), .MAX_POS(MAXP), .DEAD_CYC(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .presets(presets), .sel(sel),
        .go(go), .stop(stop), .step_en(step_en), .pos(pos),
        .motor_up(motor_up), .motor_down(motor_down),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : (v < 0) ? -1 : 0;
    endfunction

    task automatic model_step();
        int t;
        t = int'(presets[int'(sel)*POS_W +: POS_W]);
        if (t > MAXP) t = MAXP;
        m_done = 0;
        if (rst) begin
            m_pos = 0; m_tgt = 0; m_dir = 0; m_brake = 0; m_pend = 0;
        end else if (m_dir != 0) begin
            if (step_en) begin
                m_pos = m_pos + m_dir;
                if (m_pos > MAXP) m_pos = MAXP;
                if (m_pos < 0) m_pos = 0;
            end
            if (stop) begin
                m_dir = 0; m_brake = DEAD; m_pend = 0;
            end else if (go) begin
                m_tgt = t;
                if (t == m_pos) begin
                    m_dir = 0; m_done = 1;
                end else if (sgn(t - m_pos) != m_dir) begin
                    m_dir = 0; m_brake = DEAD; m_pend = 1;
                end
            end else if (m_pos == m_tgt) begin
                m_dir = 0; m_done = 1;
            end
        end else if (m_brake > 0) begin
            if (stop) m_pend = 0;
            else if (go) begin
                m_tgt = t; m_pend = 1;
            end
            m_brake--;
            if (m_brake == 0 && m_pend != 0) begin
                m_pend = 0;
                m_dir  = sgn(m_tgt - m_pos);
                if (m_dir == 0) m_done = 1;
            end
        end else if (go && !stop) begin
            m_tgt = t;
            m_dir = sgn(t - m_pos);
            if (m_dir == 0) m_done = 1;
        end
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pos", 32'(pos), 32'(m_pos));
        check("motor_up", 32'(motor_up), 32'(m_dir == 1));
        check("motor_down", 32'(motor_down), 32'(m_dir == -1));
        check("busy", 32'(busy), 32'(m_dir != 0 || m_brake > 0));
        check("done", 32'(done), 32'(m_done));
        check("pos_limit", 32'(pos > MAXP), 32'd0);
    endtask

    task automatic go_sel(input int s);
        go  = 1'b1;
        sel = SEL_W'(s);
        tick();
        go  = 1'b0;
    endtask

    task automatic run_to_done(input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        if (!done) check("timeout_done", 0, 1);
    endtask

    task automatic run_to_pos(input int p, input int lim);
        int n;
        n = 0;
        while (int'(pos) != p && n < lim) begin
            tick();
            n++;
        end
        if (int'(pos) != p) check("timeout_pos", 32'(pos), 32'(p));
    endtask

    initial begin
        int ups, brk, dones, held;
        @(negedge clk);
        presets = {8'd255, 8'd128, 8'd64, 8'd0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_pos", 32'(pos), 0);
        check("reset_busy", 32'(busy), 0);

        // Open to preset 1 with a step every cycle.
        step_en = 1'b1;
        ups = 0;
        dones = 0;
        go_sel(1);
        if (motor_up) ups++;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (motor_up) ups++;
            if (done) dones++;
        end
        check("up_cycles", 32'(ups), 64);
        check("pos_64", 32'(pos), 64);
        check("done_pulses", 32'(dones), 1);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);

        // Re-request the current position.
        go_sel(1);
        check("same_done", 32'(done), 1);
        check("same_motor", 32'(motor_up | motor_down), 0);
        tick();

        // Reverse mid-travel.
        go_sel(2);
        run_to_pos(80, 100);
        go_sel(0);
        brk = 0;
        for (int i = 0; i < 10 && !motor_down; i++) begin
            if (busy && !motor_up && !motor_down) brk++;
            tick();
        end
        check("brake_cycles", 32'(brk), DEAD);
        run_to_done(200);
        check("rev_pos0", 32'(pos), 0);
        tick();

        // Preset above the limit stops at the limit.
        go_sel(3);
        run_to_done(300);
        check("clamp_pos", 32'(pos), MAXP);
        tick();

        // Stop and go together while moving down; stop wins.
        go_sel(1);
        tick();
        tick();
        go   = 1'b1;
        stop = 1'b1;
        sel  = 2'd0;
        tick();
        go   = 1'b0;
        stop = 1'b0;
        held = int'(pos);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step_en = ~step_en;
            tick();
            if (done) dones++;
        end
        check("stop_held", 32'(pos), 32'(held));
        check("stop_no_done", 32'(dones), 0);
        check("stop_idle", 32'(busy), 0);
        step_en = 1'b1;

        // Reset mid-motion.
        go_sel(0);
        run_to_done(300);
        go_sel(3);
        run_to_pos(30, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_pos", 32'(pos), 0);
        check("rst_motor", 32'(motor_up | motor_down | busy | done), 0);
        go_sel(1);
        run_to_done(100);
        check("after_rst_pos", 32'(pos), 64);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 599) == 0);
            go      = ($urandom_range(0, 11) == 0);
            stop    = ($urandom_range(0, 29) == 0);
            step_en = ($urandom_range(0, 2) != 0);
            sel     = SEL_W'($urandom_range(0, NP - 1));
            if ($urandom_range(0, 149) == 0) begin
                for (int k = 1; k < NP; k++)
                    presets[k*POS_W +: POS_W] = POS_W'($urandom_range(0, 255));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blinds_motor_ctrl.md
BLINDS_MOTOR_CTRL -- requirements
Module: blinds_motor_ctrl

Interface
REQ-001 Parameter POS_W, default 8, blind position width in steps.
REQ-002 Parameter SEL_W, default 2, preset select width; N_PRESET = 2**SEL_W presets.
REQ-003 Parameter MAX_POS, default 2**POS_W-1, fully-open position limit.
REQ-004 Parameter DEAD_CYC, default 2, motor-off cycles required before any direction change, range 1..15.
REQ-005 Port clk  input  1  system clock; all logic on rising edge.
REQ-006 Port rst  input  1  reset, synchronous and active-high.
REQ-007 Port presets  input  N_PRESET*POS_W  preset positions; preset i at bits [i*POS_W +: POS_W]; preset 0 = closed.
REQ-008 Port sel  input  SEL_W  preset index, sampled only when go=1.
REQ-009 Port go  input  1  single-cycle move request.
REQ-010 Port stop  input  1  abort request.
REQ-011 Port step_en  input  1  motor step tick; one position step per tick while moving.
REQ-012 Port pos  output  POS_W  current position, registered.
REQ-013 Port motor_up / motor_down  output  1 each  motor drive, registered, never both high.
REQ-014 Port busy  output  1  high when state != IDLE.
REQ-015 Port done  output  1  one-cycle pulse on arrival at target.

Function
REQ-016 FSM states SHALL be IDLE, UP, DOWN, BRAKE; motor_up=1 only in UP, motor_down=1 only in DOWN.
REQ-017 Target SHALL be tgt = min(presets[sel], MAX_POS), latched on the go cycle.
REQ-018 IDLE + go: next state UP if tgt>pos, DOWN if tgt<pos; if tgt==pos stay IDLE and pulse done next cycle.
REQ-019 UP + step_en: pos <= pos+1; DOWN + step_en: pos <= pos-1; step_en ignored in IDLE and BRAKE.
REQ-020 On the edge where pos becomes tgt, state SHALL go to IDLE and done SHALL be high in that same following cycle, motors off.
REQ-021 pos SHALL never exceed MAX_POS nor wrap below 0.
REQ-022 go while moving, same direction or new tgt beyond pos in current direction: tgt updated, no motor interruption.
REQ-023 go while moving with new tgt == pos: IDLE next cycle, done pulse.
REQ-024 go while moving requiring reversal: enter BRAKE, set pending flag; after DEAD_CYC cycles resolve direction from tgt vs pos.
REQ-025 go during BRAKE: tgt updated, pending set, dead-time counter NOT restarted.
REQ-026 stop in UP/DOWN: enter BRAKE with pending cleared; BRAKE expiry with pending clear -> IDLE, no done; pos retained.
REQ-027 stop in IDLE or BRAKE: pending cleared, no other effect.
REQ-028 go and stop same cycle: stop wins, go discarded.
REQ-029 step_en and direction-ending go same cycle: step applied first, then new tgt compared against updated pos.

Reset
REQ-030 rst SHALL set pos=0, tgt=0, state=IDLE, pending=0, dead counter=0, motor_up=motor_down=busy=done=0 at next edge.
REQ-031 rst mid-motion SHALL drop motors the cycle after assertion and discard any pending request; rst overrides all inputs.

Verification
REQ-032 presets {p3=255,p2=128,p1=64,p0=0}, reset, sel=1 go, step_en=1 -> motor_up 64 cycles, pos=64, done one pulse, busy low.
REQ-033 From pos=64, sel=1 go -> no motor activity, done pulse next cycle.
REQ-034 Moving UP toward 128 at pos=80, go sel=0 -> motors off DEAD_CYC=2 cycles (BRAKE), then motor_down to pos=0, done.
REQ-035 MAX_POS=200, sel=3 go -> pos stops at 200, done; pos never 201.
REQ-036 Moving DOWN, go and stop same cycle -> BRAKE 2 cycles, IDLE, no done, pos held; step_en toggling in BRAKE -> pos unchanged.
REQ-037 rst asserted at pos=30 while UP -> pos=0, all outputs 0 next cycle; later go sel=1 works normally.
